// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: double-dabble binary-to-BCD conversion
// followed by continuous time-multiplexing of the digits onto a shared decoder.
module seg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [13:0] value,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  an,
  output logic [3:0]  digit
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e          state_q, state_d;
  logic [13:0]     bin_q, bin_d;
  logic [15:0]     bcd_q, bcd_d;
  logic [15:0]     disp_q, disp_d;
  logic [3:0]      step_q, step_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;

  logic [15:0]     bcd_adj;
  logic [3:0]      blank;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    step_d  = step_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          if (value > 14'd9999) begin
            bin_d = 14'd9999;
            ovf_d = 1'b1;
          end else begin
            bin_d = value;
            ovf_d = 1'b0;
          end
          bcd_d   = 16'd0;
          step_d  = 4'd0;
          busy_d  = 1'b1;
          state_d = StConv;
        end
      end
      StConv: begin
        bcd_d  = {bcd_adj[14:0], bin_q[13]};
        bin_d  = {bin_q[12:0], 1'b0};
        step_d = step_q + 4'd1;
        if (step_q == 4'd13) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        disp_d  = bcd_q;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Refresh scan runs regardless of conversion state.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      bin_q   <= 14'd0;
      bcd_q   <= 16'd0;
      disp_q  <= 16'd0;
      step_q  <= 4'd0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // A position is blank when it and every more significant digit are zero.
  always_comb begin
    blank    = 4'b0000;
    blank[1] = (disp_q[15:4] == 12'd0);
    blank[2] = (disp_q[15:8] == 8'd0);
    blank[3] = (disp_q[15:12] == 4'd0);
  end

  always_comb begin
    digit = 4'd0;
    unique case (idx_q)
      2'd0: digit = disp_q[3:0];
      2'd1: digit = disp_q[7:4];
      2'd2: digit = disp_q[11:8];
      2'd3: digit = disp_q[15:12];
      default: digit = 4'd0;
    endcase
    if (BLANK_LZ && blank[idx_q]) begin
      an = 4'b1111;
    end else begin
      an = ~(4'b0001 << idx_q);
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised and directed bench for seg_scan_ctrl, checked every cycle against a
// decimal-arithmetic model of conversion latency, saturation, scanning and blanking.
module tb_seg_scan_ctrl;

  localparam int unsigned Div = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic [13:0] value;
  logic        busy, ovf;
  logic [3:0]  an, digit;
  logic        busy_nb, ovf_nb;
  logic [3:0]  an_nb, digit_nb;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_edges;      // non-reset edges since last reset
  int m_disp;       // displayed decimal value
  int m_pend;       // value being converted
  int m_busy_cnt;   // cycles of busy remaining
  bit m_ovf;

  seg_scan_ctrl #(.REFRESH_DIV(Div), .BLANK_LZ(1'b1)) u_dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy), .ovf(ovf), .an(an), .digit(digit)
  );

  seg_scan_ctrl #(.REFRESH_DIV(Div), .BLANK_LZ(1'b0)) u_dut_nb (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy_nb), .ovf(ovf_nb), .an(an_nb), .digit(digit_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  function automatic int exp_an(input int idx, input bit blank_lz);
    if (blank_lz && idx >= 1 && m_disp < pow10(idx)) return 4'b1111;
    return (~(1 << idx)) & 4'hF;
  endfunction

  task automatic tick(input logic l, input int v, input logic r);
    int idx;
    load  = l;
    value = v[13:0];
    rst   = r;
    @(posedge clk);
    if (r) begin
      m_edges    = 0;
      m_disp     = 0;
      m_busy_cnt = 0;
      m_ovf      = 1'b0;
    end else begin
      m_edges++;
      if (m_busy_cnt > 0) begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) m_disp = m_pend;
      end else if (l) begin
        m_pend     = (v > 9999) ? 9999 : v;
        m_ovf      = (v > 9999);
        m_busy_cnt = 15;
      end
    end
    #1;
    idx = (m_edges / Div) % 4;
    check_eq("busy", int'(busy), int'(m_busy_cnt > 0));
    check_eq("ovf", int'(ovf), int'(m_ovf));
    check_eq("digit", int'(digit), (m_disp / pow10(idx)) % 10);
    check_eq("an", int'(an), exp_an(idx, 1'b1));
    check_eq("digit_nb", int'(digit_nb), (m_disp / pow10(idx)) % 10);
    check_eq("an_nb", int'(an_nb), exp_an(idx, 1'b0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 1'b0);
  endtask

  task automatic do_load(input int v);
    tick(1'b1, v, 1'b0);
  endtask

  initial begin
    m_edges = 0; m_disp = 0; m_pend = 0; m_busy_cnt = 0; m_ovf = 1'b0;
    load = 1'b0; value = 14'd0; rst = 1'b1;

    tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b1);
    idle(20);

    // Directed sequences, each followed by a full scan rotation
    do_load(1234);  idle(32);
    do_load(7);     idle(32);
    do_load(105);   idle(32);
    do_load(12000); idle(32);
    do_load(42);    idle(32);

    // Load while busy is ignored
    do_load(1234);  idle(4);
    do_load(5678);  idle(16);
    do_load(5678);  idle(32);

    // Reset mid-conversion
    do_load(9876);  idle(7);
    tick(1'b0, 0, 1'b1);
    do_load(31);    idle(32);

    // Back-to-back accepted loads every 16 cycles
    do_load(16383); idle(15);
    do_load(0);     idle(15);
    do_load(9999);  idle(15);
    do_load(10000); idle(20);

    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 7) == 0), $urandom_range(0, 16383), ($urandom_range(0, 99) == 0));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
